// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit.
// Holds the fetch FSM states and the memory byte-limit helper.
package fetch_pkg;

    typedef enum logic {
        RUN,
        END
    } fetch_state_e;

    localparam int XLEN       = 32;
    localparam int WORD_BYTES = XLEN / 8;

    function automatic logic [63:0] byte_limit(
        input int unsigned width,
        input int unsigned depth
    );
        return 64'(width / 8) * 64'(depth);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Memory and decode-side signals of the fetch unit.
// The fetch unit uses master; memory/decode models use slave.
interface instruction_fetch_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] FetchUnit_ImemAddr;
    logic [WIDTH-1:0] FetchUnit_ImemData;
    logic             FetchUnit_Redirect;
    logic [WIDTH-1:0] FetchUnit_RedirectPC;
    logic             FetchUnit_Valid;
    logic             FetchUnit_Ready;
    logic [WIDTH-1:0] FetchUnit_Instr;
    logic [WIDTH-1:0] FetchUnit_InstrPC;
    logic             FetchUnit_Done;

    modport master (
        output FetchUnit_ImemAddr,
        input  FetchUnit_ImemData,
        input  FetchUnit_Redirect,
        input  FetchUnit_RedirectPC,
        output FetchUnit_Valid,
        input  FetchUnit_Ready,
        output FetchUnit_Instr,
        output FetchUnit_InstrPC,
        output FetchUnit_Done
    );

    modport slave (
        input  FetchUnit_ImemAddr,
        output FetchUnit_ImemData,
        output FetchUnit_Redirect,
        output FetchUnit_RedirectPC,
        input  FetchUnit_Valid,
        output FetchUnit_Ready,
        input  FetchUnit_Instr,
        input  FetchUnit_InstrPC,
        input  FetchUnit_Done
    );
endinterface

// File: rtl/fetch_queue.sv
// Small FIFO of {instr, pc} pairs between memory and decode.
// Flush empties it in one cycle; push on full is only legal with pop.
module fetch_queue #(
    parameter int WIDTH  = 32,
    parameter int QDEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_instr,
    input  logic [WIDTH-1:0] i_pc,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head_instr,
    output logic [WIDTH-1:0] o_head_pc
);
    localparam int AW = $clog2(QDEPTH);

    logic [WIDTH-1:0] r_instr [QDEPTH];
    logic [WIDTH-1:0] r_pc    [QDEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_instr[r_wptr] <= i_instr;
            r_pc[r_wptr]    <= i_pc;
        end
    end

    assign o_full       = (r_count == (AW+1)'(QDEPTH));
    assign o_empty      = (r_count == '0);
    assign o_head_instr = r_instr[r_rptr];
    assign o_head_pc    = r_pc[r_rptr];
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch unit: PC register, RUN/END FSM and queue control.
// Redirect beats push/pop; reset beats everything.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 100,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               QDEPTH   = 2
) (
    input logic                      CLK,
    input logic                      RST,
    instruction_fetch_unit_if.master fu
);
    localparam logic [63:0]      LIMIT = byte_limit(WIDTH, DEPTH);
    localparam logic [WIDTH-1:0] STEP  = WIDTH'(WIDTH / 8);

    function automatic logic in_range(input logic [WIDTH-1:0] a);
        return 64'(a) < LIMIT;
    endfunction

    fetch_state_e     r_state;
    fetch_state_e     w_state_nxt;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [WIDTH-1:0] w_pc_inc;
    logic [WIDTH-1:0] w_redir_pc;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic [WIDTH-1:0] w_head_instr;
    logic [WIDTH-1:0] w_head_pc;

    assign w_pc_inc   = r_pc + STEP;
    assign w_redir_pc = fu.FetchUnit_RedirectPC & ~WIDTH'(3);
    assign w_pop      = !w_empty && fu.FetchUnit_Ready
                      && !fu.FetchUnit_Redirect;
    assign w_push     = (r_state == RUN) && !fu.FetchUnit_Redirect
                      && (!w_full || w_pop);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc    <= RESET_PC;
            r_state <= in_range(RESET_PC) ? RUN : END;
        end else begin
            r_pc    <= w_pc_nxt;
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_pc_nxt    = r_pc;
        w_state_nxt = r_state;
        unique case (1'b1)
            fu.FetchUnit_Redirect: begin
                w_pc_nxt    = w_redir_pc;
                w_state_nxt = in_range(w_redir_pc) ? RUN : END;
            end
            w_push: begin
                w_pc_nxt = w_pc_inc;
                if (!in_range(w_pc_inc)) w_state_nxt = END;
            end
            default: ;
        endcase
    end

    fetch_queue #(
        .WIDTH  (WIDTH),
        .QDEPTH (QDEPTH)
    ) u_queue (
        .i_clk        (CLK),
        .i_rst        (RST),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_flush      (fu.FetchUnit_Redirect),
        .i_instr      (fu.FetchUnit_ImemData),
        .i_pc         (r_pc),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_head_instr (w_head_instr),
        .o_head_pc    (w_head_pc)
    );

    assign fu.FetchUnit_ImemAddr = r_pc;
    assign fu.FetchUnit_Valid    = !w_empty;
    assign fu.FetchUnit_Instr    = w_empty ? '0 : w_head_instr;
    assign fu.FetchUnit_InstrPC  = w_empty ? '0 : w_head_pc;
    assign fu.FetchUnit_Done     = (r_state == END) && w_empty;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed scenarios
// followed by randomized ready/redirect/reset traffic.
module tb_instruction_fetch_unit;

    localparam int          DEPTH = 100;
    localparam logic [31:0] LIMIT = 32'd400;
    localparam int          QD    = 2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic CLK = 1'b0;
    logic RST;

    instruction_fetch_unit_if #(.WIDTH(32)) ifc ();

    instruction_fetch_unit #(
        .WIDTH    (32),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0),
        .QDEPTH   (QD)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .fu  (ifc)
    );

    always #5 CLK = ~CLK;

    logic [31:0] mem [DEPTH];

    function automatic logic [31:0] rd(input logic [31:0] a);
        int idx;
        if (a >= LIMIT) return 32'h0;
        idx = int'(a >> 2);
        return mem[idx];
    endfunction

    assign ifc.FetchUnit_ImemData = rd(ifc.FetchUnit_ImemAddr);

    // Reference: PC in range means fetching; queue holds what was fetched.
    logic [31:0] mpc;
    int          mcount = 0;
    ent_t        sb[$];
    bit          mon_en = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", n, a, e, $time);
        end
    endtask

    always @(posedge CLK) begin
        bit pop;
        bit push;
        if (RST) begin
            mpc    = 32'h0;
            mcount = 0;
            sb.delete();
            mon_en = 1;
        end else if (mon_en) begin
            if (ifc.FetchUnit_Redirect) begin
                sb.delete();
                mcount = 0;
                mpc    = ifc.FetchUnit_RedirectPC & 32'hFFFF_FFFC;
            end else begin
                pop  = (mcount > 0) && ifc.FetchUnit_Ready;
                push = (mpc < LIMIT) && ((mcount < QD) || pop);
                if (push) begin
                    sb.push_back('{instr: rd(mpc), pc: mpc});
                    mpc = mpc + 32'd4;
                end
                mcount = mcount + int'(push) - int'(pop);
            end
        end
    end

    always @(negedge CLK) begin
        ent_t e;
        if (mon_en) begin
            chk("imem_addr", ifc.FetchUnit_ImemAddr, mpc);
            chk("valid", 32'(ifc.FetchUnit_Valid), 32'(mcount > 0));
            chk("done", 32'(ifc.FetchUnit_Done),
                32'((mpc >= LIMIT) && (mcount == 0)));
            if (!ifc.FetchUnit_Valid) begin
                chk("idle_instr", ifc.FetchUnit_Instr, 32'h0);
                chk("idle_pc", ifc.FetchUnit_InstrPC, 32'h0);
            end
            if (ifc.FetchUnit_Valid && ifc.FetchUnit_Ready
                && !ifc.FetchUnit_Redirect && !RST) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_empty actual=pc %h required=none",
                             ifc.FetchUnit_InstrPC);
                end else begin
                    e = sb.pop_front();
                    chk("instr", ifc.FetchUnit_Instr, e.instr);
                    chk("instr_pc", ifc.FetchUnit_InstrPC, e.pc);
                end
            end
        end
    end

    task automatic cyc(input bit rst, input bit rdy, input bit red,
                       input logic [31:0] tgt, input int n);
        repeat (n) begin
            RST                      = rst;
            ifc.FetchUnit_Ready      = rdy;
            ifc.FetchUnit_Redirect   = red;
            ifc.FetchUnit_RedirectPC = tgt;
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        logic [31:0] tgt;
        bit          r;
        bit          rdy;
        bit          red;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[0] = 32'h2008_0001;
        mem[1] = 32'h2009_0002;
        mem[2] = 32'h0109_5020;
        mem[3] = 32'h0000_0000;

        // reset then stream
        cyc(1, 0, 0, 0, 2);
        cyc(0, 1, 0, 0, 6);
        // backpressure
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 5);
        cyc(0, 1, 0, 0, 4);
        // redirect with full queue
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 3);
        cyc(0, 1, 1, 32'h2A, 1);
        cyc(0, 1, 0, 0, 4);
        // end of memory, then restart
        cyc(0, 1, 1, 32'h188, 1);
        cyc(0, 1, 0, 0, 8);
        cyc(0, 1, 1, 32'h0, 1);
        cyc(0, 1, 0, 0, 3);
        // reset together with redirect, queue full
        cyc(0, 0, 0, 0, 3);
        cyc(1, 1, 1, 32'h40, 1);
        cyc(0, 1, 0, 0, 3);
        // out-of-range redirect
        cyc(0, 1, 1, 32'h400, 1);
        cyc(0, 1, 0, 0, 3);

        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 199) == 0);
            red = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0:       tgt = $urandom_range(0, 399);
                1:       tgt = 32'd384 + $urandom_range(0, 15);
                2:       tgt = $urandom;
                default: tgt = $urandom_range(0, 40);
            endcase
            cyc(r, rdy, red, tgt, 1);
        end
        cyc(0, 1, 0, 0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
